// File: rtl/sdr_16_pkg.sv
// Shared sdr_16 constants: data widths, legal CAS latencies and read-return timing.
// Used by the read-capture block and the controller FSM.
package sdr_16_pkg;

  localparam int BEAT_W       = 16;
  localparam int WORD_W       = 2 * BEAT_W;
  localparam int CL_MIN       = 2;
  localparam int CL_MAX       = 3;
  localparam int IO_DELAY_MAX = 2;

  function automatic bit cl_legal(input int cl);
    return (cl >= CL_MIN) && (cl <= CL_MAX);
  endfunction

  // Cycles from the scheduling of a READ to the first data beat at the block:
  // one cycle for the command to reach the pins, CL in the SDRAM, IO_DELAY in the pads.
  function automatic int rd_delay(input int cl, input int io_delay);
    return 1 + cl + io_delay;
  endfunction

endpackage

// File: rtl/sdr_16_dly_line.sv
// Fixed-depth 1-bit shift register; taps[i] is the input delayed by i+1 cycles.
module sdr_16_dly_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sdr_16_dly_line: DEPTH must be at least 2");
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/sdr_16_rd_capture.sv
// SDRAM burst-length-2 read capture: times each READ with a tag shift register,
// samples both 16-bit beats and emits one packed 32-bit word to the egress FIFO.
module sdr_16_rd_capture
  import sdr_16_pkg::*;
#(
  parameter int CL       = 2,
  parameter int IO_DELAY = 1
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst_n,
  input  logic              cmd_read,
  input  logic [BEAT_W-1:0] dq_i,
  input  logic              fifo_full,
  output logic [WORD_W-1:0] dat_o,
  output logic              fifo_we,
  output logic              busy,
  output logic              overrun,
  output logic              proto_err
);

  localparam int D = rd_delay(CL, IO_DELAY);

  generate
    if (!cl_legal(CL)) begin : g_bad_cl
      $error("sdr_16_rd_capture: CL must be 2 or 3");
    end
    if ((IO_DELAY < 0) || (IO_DELAY > IO_DELAY_MAX)) begin : g_bad_io_delay
      $error("sdr_16_rd_capture: IO_DELAY must be 0..2");
    end
  endgenerate

  // tag[i] is high in cycle t+1+i for a READ accepted in cycle t.
  logic [D:0]        tag;
  logic              accept;
  logic [BEAT_W-1:0] beat0;
  logic              overrun_q;

  // A READ in the cycle right after an accepted one collides on the data bus;
  // it is dropped and flagged.
  assign accept = cmd_read & ~tag[0];

  sdr_16_dly_line #(
    .DEPTH (D + 1)
  ) u_tag (
    .clk   (sdram_clk),
    .rst_n (sdram_rst_n),
    .din   (accept),
    .taps  (tag)
  );

  // The FIFO has no back-pressure path: fifo_we is a write strobe that is never
  // stalled; fifo_full only records an overrun when a word lands on a full FIFO.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      beat0     <= '0;
      dat_o     <= '0;
      fifo_we   <= 1'b0;
      overrun_q <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (tag[D-1]) begin
        beat0 <= dq_i;
      end
      if (tag[D]) begin
        dat_o <= {beat0, dq_i};
      end
      fifo_we   <= tag[D];
      overrun_q <= overrun_q | (fifo_we & fifo_full);
      proto_err <= proto_err | (cmd_read & tag[0]);
    end
  end

  // overrun shows in the very cycle the word hits a full FIFO, then stays sticky.
  assign overrun = overrun_q | (fifo_we & fifo_full);
  assign busy    = (|tag) | fifo_we;

endmodule

// File: doc/sdr_16_rd_capture.md
SDR_16_RD_CAPTURE -- requirements
Module: sdr_16_rd_capture

Interface
REQ-001 SHALL have parameter: CL, 2, SDRAM CAS latency in clocks; legal values 2 and 3 only.
REQ-002 SHALL have parameter: IO_DELAY, 1, extra capture register stages between pad and block; legal values 0..2.
REQ-003 SHALL have port: sdram_clk  input  1  sole clock; every flop is rising-edge on it.
REQ-004 SHALL have port: sdram_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: cmd_read  input  1  high for one cycle when the controller FSM schedules a READ; the command reaches the pins one cycle later.
REQ-006 SHALL have port: dq_i  input  16  SDRAM data bus, already registered IO_DELAY times.
REQ-007 SHALL have port: fifo_full  input  1  egress FIFO full.
REQ-008 SHALL have port: dat_o  output  32  assembled read word.
REQ-009 SHALL have port: fifo_we  output  1  one-cycle egress FIFO write strobe qualifying dat_o.
REQ-010 SHALL have port: busy  output  1  high while any read is in flight.
REQ-011 SHALL have port: overrun  output  1  sticky; set when a word is produced while fifo_full is high.
REQ-012 SHALL have port: proto_err  output  1  sticky; set on illegal cmd_read spacing.

Function
REQ-013 SHALL treat each accepted cmd_read as a burst-length-2 read returning exactly two 16-bit beats.
REQ-014 SHALL define D = 1 + CL + IO_DELAY; for cmd_read accepted in cycle t, it SHALL sample beat0 from dq_i at the end of cycle t+D and beat1 at the end of cycle t+D+1.
REQ-015 SHALL set dat_o = {beat0, beat1} (beat0 in bits 31:16) and pulse fifo_we in cycle t+D+2.
REQ-016 SHALL implement timing with a D+1-bit tag shift register advanced every cycle, not with a counter.
REQ-017 SHALL accept cmd_read in back-to-back bursts spaced exactly 2 cycles apart and produce fifo_we pulses spaced exactly 2 cycles apart.
REQ-018 SHALL ignore a cmd_read asserted in the cycle immediately after an accepted cmd_read, and SHALL set proto_err; the earlier read SHALL complete normally.
REQ-019 SHALL still pulse fifo_we and drive dat_o when fifo_full is high, set overrun in the same cycle, and never stall.
REQ-020 SHALL drive busy high from the cycle after an accepted cmd_read through the cycle fifo_we pulses for the last outstanding read; busy is combinational from the tag register OR'd with the pack stage.
REQ-021 SHALL hold dat_o at its last value when fifo_we is low.
REQ-022 SHALL clear overrun and proto_err only by reset.
REQ-023 SHALL hard-select CL at elaboration; an illegal CL or IO_DELAY SHALL make elaboration fail.

Reset
REQ-024 SHALL, on sdram_rst_n low, immediately clear the tag register, the beat registers, dat_o (32'h0), fifo_we (0), busy (0), overrun (0) and proto_err (0).
REQ-025 SHALL drop every in-flight read if reset asserts mid-burst, with no fifo_we after release for reads issued before reset.
REQ-026 SHALL accept a cmd_read in the first cycle after reset release.

Structure
REQ-027 SHALL take CL legal values and the data widths (16-bit beat, 32-bit word) from the shared sdr_16 constants package, also used by the controller FSM.
REQ-028 SHALL place the tag shift register in one sub-module, sdr_16_dly_line (parameter DEPTH, 1-bit in, DEPTH-bit tap vector out); the beat packing stays in the top module.

Verification
REQ-029 SHALL cover: CL=2, IO_DELAY=1, single cmd_read at cycle 10, dq_i=16'hA5A5 then 16'h5A5A at the sample points -> fifo_we at cycle 16 with dat_o=32'hA5A55A5A; busy high in cycles 11..16.
REQ-030 SHALL cover: CL=3, IO_DELAY=0, cmd_read at cycles 4, 6, 8, 10 with beats 16'h0001..16'h0008 -> fifo_we at 10, 12, 14, 16 with dat_o 32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008.
REQ-031 SHALL cover: cmd_read at cycles 5 and 6 -> one word only, for the cycle-5 read; proto_err set from cycle 7 and held.
REQ-032 SHALL cover: fifo_full held high during a read's fifo_we cycle -> fifo_we still pulses; overrun rises in that cycle and stays high until reset.
REQ-033 SHALL cover: sdram_rst_n pulsed low between beat0 and beat1 of a read -> all outputs 0 at once; no fifo_we after release; a new cmd_read issued right after release returns correct data.
